// File: rtl/pic_prio_resolver_n_if.sv
// Bus bundle between the interrupt controller core and its priority resolver.
// The master side drives requests and commands; the slave side is the resolver.
interface pic_prio_resolver_n_if #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] ir_in;
    logic [NUM_IRQ-1:0] imr;
    logic               ltim;
    logic               rot_mode;
    logic               aeoi;
    logic               inta;
    logic               eoi_req;
    logic               eoi_spec;
    logic [ID_W-1:0]    eoi_lvl;
    logic               setp_req;
    logic [ID_W-1:0]    setp_lvl;
    logic               int_out;
    logic               vec_valid;
    logic [ID_W-1:0]    vec_id;
    logic               spurious;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;
    logic [ID_W-1:0]    lowest;

    modport master (
        output ir_in, imr, ltim, rot_mode, aeoi, inta,
               eoi_req, eoi_spec, eoi_lvl, setp_req, setp_lvl,
        input  int_out, vec_valid, vec_id, spurious, irr, isr, lowest
    );

    modport slave (
        input  ir_in, imr, ltim, rot_mode, aeoi, inta,
               eoi_req, eoi_spec, eoi_lvl, setp_req, setp_lvl,
        output int_out, vec_valid, vec_id, spurious, irr, isr, lowest
    );
endinterface

// File: rtl/pic_prio_resolver_n.sv
// N-channel PIC priority resolver: IRR/ISR ownership, nested or rotating priority,
// three-state acknowledge sequencer and specific/non-specific/automatic EOI.
module pic_prio_resolver_n #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    pic_prio_resolver_n_if.slave  bus
);
    localparam int XW = ID_W + 2;
    localparam logic [XW-1:0]   NUM_X = XW'(NUM_IRQ);
    localparam logic [ID_W:0]   NUM_L = (ID_W + 1)'(NUM_IRQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_IRQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_VEC} state_t;

    state_t             state_reg, state_next;
    logic [NUM_IRQ-1:0] ir_q_reg;
    logic [NUM_IRQ-1:0] irr_reg, irr_next;
    logic [NUM_IRQ-1:0] isr_reg, isr_next;
    logic [ID_W-1:0]    lowest_reg, lowest_next;
    logic               int_out_reg;
    logic               vec_valid_reg, vec_valid_next;
    logic [ID_W-1:0]    vec_id_reg, vec_id_next;
    logic               spurious_reg, spurious_next;

    logic [NUM_IRQ-1:0] cand_vec, cand_rot, isr_rot;
    logic [ID_W-1:0]    src_idx [NUM_IRQ];
    logic [ID_W-1:0]    cand_pos, isr_pos, cand_id, isr_top_id;
    logic               cand_any, isr_any, cand_ok;
    logic [NUM_IRQ-1:0] ack_set, ack_clr, eoi_clr, aeoi_clr, irr_capture;
    logic               rot_hit;
    logic [ID_W-1:0]    rot_id;

    assign cand_vec = irr_reg & ~bus.imr;

    // Position gi in the rotated view is channel (lowest+1+gi) mod NUM_IRQ,
    // so position 0 is always the highest-priority channel.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_rot
        logic [XW-1:0] raw;
        assign raw          = {2'b00, lowest_reg} + XW'(gi + 1);
        assign src_idx[gi]  = (raw >= NUM_X) ? ID_W'(raw - NUM_X) : ID_W'(raw);
        assign cand_rot[gi] = cand_vec[src_idx[gi]];
        assign isr_rot[gi]  = isr_reg[src_idx[gi]];
    end

    always_comb begin
        cand_pos = '0;
        cand_any = 1'b0;
        isr_pos  = '0;
        isr_any  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand_rot[i]) begin
                cand_pos = ID_W'(i);
                cand_any = 1'b1;
            end
            if (isr_rot[i]) begin
                isr_pos = ID_W'(i);
                isr_any = 1'b1;
            end
        end
    end

    assign cand_id    = src_idx[cand_pos];
    assign isr_top_id = src_idx[isr_pos];
    // Masked in-service bits still block: nesting is judged on raw ISR.
    assign cand_ok    = cand_any && !(isr_any && (isr_pos <= cand_pos));

    always_comb begin
        state_next     = state_reg;
        ack_set        = '0;
        ack_clr        = '0;
        aeoi_clr       = '0;
        eoi_clr        = '0;
        vec_id_next    = vec_id_reg;
        spurious_next  = spurious_reg;
        vec_valid_next = 1'b0;
        rot_hit        = 1'b0;
        rot_id         = '0;

        case (state_reg)
            S_IDLE: begin
                if (bus.inta) state_next = S_ACK;
            end
            S_ACK: begin
                if (cand_ok) begin
                    ack_set[cand_id] = 1'b1;
                    ack_clr[cand_id] = 1'b1;
                    vec_id_next      = cand_id;
                    spurious_next    = 1'b0;
                end else begin
                    vec_id_next   = LAST_ID;
                    spurious_next = 1'b1;
                end
                state_next = S_VEC;
            end
            S_VEC: begin
                vec_valid_next = 1'b1;
                if (bus.aeoi && !spurious_reg) begin
                    aeoi_clr[vec_id_reg] = 1'b1;
                    rot_hit              = 1'b1;
                    rot_id               = vec_id_reg;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // EOI target comes from the pre-cycle ISR, independent of any ACK set.
        if (bus.eoi_req) begin
            if (bus.eoi_spec) begin
                if ({1'b0, bus.eoi_lvl} < NUM_L) eoi_clr[bus.eoi_lvl] = 1'b1;
            end else if (isr_any) begin
                eoi_clr[isr_top_id] = 1'b1;
                rot_hit             = 1'b1;
                rot_id              = isr_top_id;
            end
        end

        irr_capture = bus.ltim ? bus.ir_in : (irr_reg | (bus.ir_in & ~ir_q_reg));
        irr_next    = irr_capture & ~ack_clr;
        isr_next    = (isr_reg | ack_set) & ~(eoi_clr | aeoi_clr);

        lowest_next = lowest_reg;
        if (bus.rot_mode && rot_hit) lowest_next = rot_id;
        if (bus.setp_req && ({1'b0, bus.setp_lvl} < NUM_L)) lowest_next = bus.setp_lvl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ir_q_reg      <= '0;
            irr_reg       <= '0;
            isr_reg       <= '0;
            lowest_reg    <= LAST_ID;
            int_out_reg   <= 1'b0;
            vec_valid_reg <= 1'b0;
            vec_id_reg    <= '0;
            spurious_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ir_q_reg      <= bus.ir_in;
            irr_reg       <= irr_next;
            isr_reg       <= isr_next;
            lowest_reg    <= lowest_next;
            int_out_reg   <= cand_ok;
            vec_valid_reg <= vec_valid_next;
            vec_id_reg    <= vec_id_next;
            spurious_reg  <= spurious_next;
        end
    end

    assign bus.int_out   = int_out_reg;
    assign bus.vec_valid = vec_valid_reg;
    assign bus.vec_id    = vec_id_reg;
    assign bus.spurious  = spurious_reg;
    assign bus.irr       = irr_reg;
    assign bus.isr       = isr_reg;
    assign bus.lowest    = lowest_reg;
endmodule

// File: tb/tb_pic_prio_resolver_n.sv
// Directed bench for pic_prio_resolver_n: acknowledge vectors go through a
// scoreboard queue checked by a monitor; register state is checked inline.
module tb_pic_prio_resolver_n;
    localparam int N  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [IW-1:0] id;
        logic          spur;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];

    pic_prio_resolver_n_if #(.NUM_IRQ(N), .ID_W(IW)) bus ();

    pic_prio_resolver_n #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every vec_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.vec_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL vec_unexpected: got id=%0d spurious=%0b, required no pulse",
                         bus.vec_id, bus.spurious);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.vec_id !== e.id || bus.spurious !== e.spur) begin
                    n_miss++;
                    $display("FAIL vec: got id=%0d spurious=%0b, required id=%0d spurious=%0b",
                             bus.vec_id, bus.spurious, e.id, e.spur);
                end else begin
                    $display("ok   vec: id=%0d spurious=%0b", bus.vec_id, bus.spurious);
                end
            end
        end
    end

    task automatic do_ack(input logic [IW-1:0] id, input logic spur);
        exp_t e;
        e.id   = id;
        e.spur = spur;
        exp_q.push_back(e);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_ir(input logic [N-1:0] v);
        bus.ir_in = v;
        tick();
        bus.ir_in = '0;
        tick();
    endtask

    task automatic eoi(input logic spec, input logic [IW-1:0] lvl);
        bus.eoi_req  = 1'b1;
        bus.eoi_spec = spec;
        bus.eoi_lvl  = lvl;
        tick();
        bus.eoi_req  = 1'b0;
        bus.eoi_spec = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.ir_in    = '0;
        bus.imr      = '0;
        bus.ltim     = 1'b0;
        bus.rot_mode = 1'b0;
        bus.aeoi     = 1'b0;
        bus.inta     = 1'b0;
        bus.eoi_req  = 1'b0;
        bus.eoi_spec = 1'b0;
        bus.eoi_lvl  = '0;
        bus.setp_req = 1'b0;
        bus.setp_lvl = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_irr", 32'(bus.irr), 32'h00);
        check("rst_isr", 32'(bus.isr), 32'h00);
        check("rst_lowest", 32'(bus.lowest), 32'd7);
        check("rst_int_out", 32'(bus.int_out), 32'd0);
        check("rst_vec_id", 32'(bus.vec_id), 32'd0);

        // Edge request on IR3 and its acknowledge
        bus.ir_in = 8'h08;
        tick();
        check("t1_irr_set", 32'(bus.irr), 32'h08);
        check("t1_int_lag", 32'(bus.int_out), 32'd0);
        bus.ir_in = '0;
        tick();
        check("t1_int_out", 32'(bus.int_out), 32'd1);
        check("t1_irr_held", 32'(bus.irr), 32'h08);
        do_ack(3'd3, 1'b0);
        check("t1_isr", 32'(bus.isr), 32'h08);
        check("t1_irr", 32'(bus.irr), 32'h00);
        check("t1_int_drop", 32'(bus.int_out), 32'd0);

        // Nesting: IR5 blocked by IR3 in service, IR1 preempts
        bus.ir_in = 8'h20;
        repeat (2) tick();
        check("t2_ir5_blocked", 32'(bus.int_out), 32'd0);
        check("t2_irr5", 32'(bus.irr), 32'h20);
        bus.ir_in = 8'h22;
        repeat (2) tick();
        check("t2_ir1_int", 32'(bus.int_out), 32'd1);
        do_ack(3'd1, 1'b0);
        check("t2_isr_nested", 32'(bus.isr), 32'h0A);
        check("t2_irr_left", 32'(bus.irr), 32'h20);
        bus.ir_in = '0;
        eoi(1'b0, 3'd0);
        check("t2_ns_eoi", 32'(bus.isr), 32'h08);
        tick();
        check("t2_still_blk", 32'(bus.int_out), 32'd0);
        eoi(1'b1, 3'd3);
        check("t2_spec_eoi", 32'(bus.isr), 32'h00);
        tick();
        check("t2_ir5_int", 32'(bus.int_out), 32'd1);
        do_ack(3'd5, 1'b0);
        eoi(1'b1, 3'd5);
        check("t2_clean_isr", 32'(bus.isr), 32'h00);
        check("t2_lowest", 32'(bus.lowest), 32'd7);

        // Automatic rotation on non-specific EOI
        bus.rot_mode = 1'b1;
        pulse_ir(8'h04);
        do_ack(3'd2, 1'b0);
        eoi(1'b0, 3'd0);
        check("t3_rot_lowest", 32'(bus.lowest), 32'd2);
        pulse_ir(8'h11);
        do_ack(3'd4, 1'b0);
        check("t3_isr4", 32'(bus.isr), 32'h10);
        check("t3_irr0", 32'(bus.irr), 32'h01);
        eoi(1'b0, 3'd0);
        check("t3_rot4", 32'(bus.lowest), 32'd4);
        tick();
        do_ack(3'd0, 1'b0);
        eoi(1'b1, 3'd0);
        check("t3_spec_norot", 32'(bus.lowest), 32'd4);
        check("t3_isr_empty", 32'(bus.isr), 32'h00);

        // Spurious acknowledge
        do_ack(3'd7, 1'b1);
        check("t4_isr", 32'(bus.isr), 32'h00);
        check("t4_irr", 32'(bus.irr), 32'h00);

        // Level mode with automatic EOI (rotation still enabled)
        bus.ltim  = 1'b1;
        bus.aeoi  = 1'b1;
        bus.ir_in = 8'h40;
        repeat (2) tick();
        check("t5_int_out", 32'(bus.int_out), 32'd1);
        do_ack(3'd6, 1'b0);
        check("t5_isr_aeoi", 32'(bus.isr), 32'h00);
        check("t5_irr_reset", 32'(bus.irr), 32'h40);
        check("t5_int_again", 32'(bus.int_out), 32'd1);
        check("t5_aeoi_rot", 32'(bus.lowest), 32'd6);
        bus.ir_in = '0;
        tick();
        check("t5_irr_drop", 32'(bus.irr), 32'h00);
        tick();
        check("t5_int_drop", 32'(bus.int_out), 32'd0);
        bus.ltim = 1'b0;
        bus.aeoi = 1'b0;

        // Set-priority beats rotation in the same cycle
        pulse_ir(8'h04);
        do_ack(3'd2, 1'b0);
        check("t6_isr2", 32'(bus.isr), 32'h04);
        bus.setp_req = 1'b1;
        bus.setp_lvl = 3'd7;
        eoi(1'b0, 3'd0);
        bus.setp_req = 1'b0;
        check("t6_setp_wins", 32'(bus.lowest), 32'd7);
        check("t6_isr_clr", 32'(bus.isr), 32'h00);

        // Reset during ACK: no vector, everything back to reset values
        pulse_ir(8'h02);
        check("t7_int_out", 32'(bus.int_out), 32'd1);
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        rst = 1'b1;
        #1;
        check("t7_irr", 32'(bus.irr), 32'h00);
        check("t7_isr", 32'(bus.isr), 32'h00);
        check("t7_lowest", 32'(bus.lowest), 32'd7);
        check("t7_int_out_rst", 32'(bus.int_out), 32'd0);
        check("t7_vec_id", 32'(bus.vec_id), 32'd0);
        check("t7_spurious", 32'(bus.spurious), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t7_no_vec", 32'(bus.vec_valid), 32'd0);
        end
        check("t7_isr_after", 32'(bus.isr), 32'h00);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
